ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 12, address width in bits.
REQ-003 Parameter DEPTH, default 4096, number of words; SHALL be <= 2**ADDR_W.
REQ-004 Parameter CLEAR_ON_RESET, default 1; 1 = zero all words after reset, 0 = skip clear.
REQ-005 Parameter WR_RSP, default 0; 1 = writes return the pre-write word as a response, 0 = writes produce no response.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_W  word address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
REQ-014 rsp_valid  out  1  response data valid.
REQ-015 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-016 rsp_rdata  out  DATA_W  response data.
REQ-017 busy  out  1  high while the clear sequence runs.

Function
REQ-018 Two states SHALL exist: CLEAR and RUN.
REQ-019 From reset, state SHALL be CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-020 In CLEAR, each cycle SHALL write 0 to mem[cnt] and increment cnt from 0.
REQ-021 CLEAR SHALL last exactly DEPTH cycles; after the write to DEPTH-1, the next cycle SHALL be RUN.
REQ-022 busy SHALL be 1 exactly when state is CLEAR.
REQ-023 req_ready SHALL equal (state==RUN) && (!rsp_valid || rsp_ready); it is combinational and does not depend on req_valid.
REQ-024 An accepted read to address A at edge N SHALL assert rsp_valid with rsp_rdata=mem[A] after edge N+1 (1-cycle latency).
REQ-025 Accepted write: only bytes with req_be[i]=1 SHALL be updated, at the accepting edge; req_be=0 SHALL leave memory unchanged.
REQ-026 WR_RSP=1: an accepted write SHALL produce a response carrying the full word at A before the write (read-first); WR_RSP=0: rsp_valid SHALL be unaffected by writes.
REQ-027 A read accepted one cycle after a write to the same address SHALL return the new data.
REQ-028 rsp_valid and rsp_rdata SHALL hold stable while rsp_valid && !rsp_ready.
REQ-029 A response consumed in the same edge as a new read acceptance SHALL be replaced by the new response with no bubble; full throughput is one request per cycle.
REQ-030 If rsp_ready is consumed and no new response-producing request is accepted, rsp_valid SHALL fall to 0 after that edge.
REQ-031 Addresses >= DEPTH: writes SHALL be ignored; reads (and WR_RSP write responses) SHALL return 0 and still produce a response.
REQ-032 Requests SHALL NOT be accepted in CLEAR; req_valid there SHALL have no effect.

Reset
REQ-033 On rst=1 at an edge: rsp_valid=0, rsp_rdata=0, cnt=0, state per REQ-019; busy per REQ-022.
REQ-034 rst during CLEAR SHALL restart the clear from address 0.
REQ-035 rst during RUN SHALL drop any pending response; memory contents SHALL be retained when CLEAR_ON_RESET=0.
REQ-036 rst SHALL take priority over every request and response handshake in the same cycle.

Verification
REQ-037 DEPTH=16, CLEAR_ON_RESET=1: pulse rst -> busy=1 for exactly 16 cycles, req_ready=0 throughout; then reads of all addresses return 0x0000.
REQ-038 Write A=3, data 0xABCD, be=2'b11; next cycle read A=3 -> rsp_rdata=0xABCD one cycle after acceptance.
REQ-039 Write A=3, data 0x1234, be=2'b01 over 0xABCD -> subsequent read returns 0xAB34.
REQ-040 Back-to-back reads of A=1,2,3 with rsp_ready held 0 for 3 cycles after the first -> req_ready=0 while stalled, rsp_rdata holds mem[1]; responses delivered in order with no loss or duplication.
REQ-041 WR_RSP=1: write 0x5555 to A=7 holding 0x00FF -> response 0x00FF; next read of A=7 -> 0x5555.
REQ-042 DEPTH=16: read A=20 -> response 0x0000; rst asserted mid-CLEAR at cnt=9 -> clear restarts, busy=1 for 16 more cycles.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port word RAM with byte enables, an optional power-on clear
// sweep, and a one-deep registered response slot with valid/ready backpressure.
//
// state | meaning
// CLEAR | writing 0 to mem[cnt] once per cycle, requests blocked, busy high
// RUN   | serving read/write requests, one per cycle at full throughput
module ram_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 4096,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WR_RSP         = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic              accept;
    logic              in_range;
    logic              produce;
    logic              consume;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_RUN) && (!rsp_valid || rsp_ready);

    // req_ready stays a pure function of state and the response slot; reset
    // only masks the internal acceptance so it wins over any handshake.
    assign accept   = req_valid && req_ready && !rst;
    assign in_range = {1'b0, req_addr} < DEPTH_A;
    assign idx      = req_addr[IDX_W-1:0];
    assign produce  = accept && (!req_we || (WR_RSP != 0));
    assign consume  = rsp_valid && rsp_ready;
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_RUN;
            end
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = state_q;
        endcase
    end

    // Storage has no reset so contents survive rst when the clear is skipped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (accept && req_we && in_range) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (req_be[i]) begin
                        mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read-first: rd_word samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (produce) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_word;
        end else if (consume) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: drives two ram_ctrl instances (WR_RSP=0 and WR_RSP=1) with shared
// directed and random stimulus, checking both against a per-instance reference model.
module tb_ram_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int DEP = 16;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_we    = 1'b0;
    logic            rsp_ready = 1'b0;
    logic [AW-1:0]   req_addr  = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic [DW/8-1:0] req_be    = '0;
    logic [1:0]      rdy;
    logic [1:0]      rv;
    logic [1:0]      bsy;
    logic [DW-1:0]   rdat0;
    logic [DW-1:0]   rdat1;

    int errors = 0;
    int checks = 0;

    // Reference model: memory image, clear cycles left and the response slot.
    int mem_m [2][DEP];
    int clr_left [2];
    bit rv_m [2];
    int rd_m [2];
    bit last_busy0;

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CLEAR_ON_RESET(1), .WR_RSP(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rdat0), .busy(bsy[0]));

    ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CLEAR_ON_RESET(1), .WR_RSP(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rdat1), .busy(bsy[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rv_m[k]     = 1'b0;
            rd_m[k]     = 0;
            clr_left[k] = DEP;
            for (int i = 0; i < DEP; i++) mem_m[k][i] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit v, input bit we, input int a,
                              input int wd, input int be, input bit rr);
        bit acc;
        bit consumed;
        int old;
        int mask;
        if (clr_left[k] > 0) begin
            clr_left[k]--;
        end else begin
            acc      = v && (!rv_m[k] || rr);
            consumed = rv_m[k] && rr;
            old      = 0;
            if (a < DEP) old = mem_m[k][a];
            if (acc) begin
                if (we && a < DEP) begin
                    mask = (((be & 1) != 0) ? 'h00FF : 0) | (((be & 2) != 0) ? 'hFF00 : 0);
                    mem_m[k][a] = (old & ~mask) | (wd & mask);
                end
                if (!we || k == 1) begin
                    rv_m[k] = 1'b1;
                    rd_m[k] = old;
                end else if (consumed) begin
                    rv_m[k] = 1'b0;
                end
            end else if (consumed) begin
                rv_m[k] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit we, input int a,
                         input int wd, input int be, input bit rr);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = AW'(a);
        req_wdata = DW'(wd);
        req_be    = 2'(be);
        rsp_ready = rr;
        #1;
        last_busy0 = bsy[0];
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] obs_d;
            bit eb;
            bit er;
            obs_d = (k == 0) ? rdat0 : rdat1;
            eb = clr_left[k] > 0;
            er = !eb && (!rv_m[k] || rr);
            chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(eb));
            chk($sformatf("req_ready%0d", k), 32'(rdy[k]), 32'(er));
            chk($sformatf("rsp_valid%0d", k), 32'(rv[k]), 32'(rv_m[k]));
            if (rv_m[k]) chk($sformatf("rsp_rdata%0d", k), 32'(obs_d), rd_m[k]);
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) model_edge(k, v, we, a, wd, be, rr);
        end
    endtask

    task automatic rd(input int a, input bit rr);
        cycle(1'b0, 1'b1, 1'b0, a, 0, 0, rr);
    endtask

    task automatic wr(input int a, input int d, input int be);
        cycle(1'b0, 1'b1, 1'b1, a, d, be, 1'b1);
    endtask

    task automatic count_clear(input string tag);
        int nb;
        nb = 0;
        for (int i = 0; i < 24; i++) begin
            // Writes offered while clearing must be dropped; idle once it ends.
            cycle(1'b0, i < 16, 1'b1, $urandom_range(0, DEP - 1), 'hFFFF, 3, 1'b1);
            if (last_busy0) nb++;
        end
        chk(tag, nb, 16);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst_rdata", 32'(rdat0), 0);
        chk("rst_rsp_valid", 32'(rv), 0);
        chk("rst_busy", 32'(bsy), 3);

        count_clear("clear_len");
        for (int a = 0; a < DEP; a++) begin
            rd(a, 1'b1);
            #1 chk("clear_read", 32'(rdat0), 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);

        wr(3, 'hABCD, 3);
        rd(3, 1'b1);
        #1 chk("rd_abcd", 32'(rdat0), 'hABCD);
        wr(3, 'h1234, 1);
        rd(3, 1'b1);
        #1 chk("rd_ab34", 32'(rdat0), 'hAB34);
        wr(1, 'h1111, 3);
        wr(2, 'h2222, 3);
        wr(4, 'h4444, 3);
        wr(5, 'h5A5A, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);

        rd(1, 1'b1);
        #1 chk("stall_first", 32'(rdat0), 'h1111);
        for (int i = 0; i < 3; i++) begin
            rd(2, 1'b0);
            #1;
            chk("stall_hold", 32'(rdat0), 'h1111);
            chk("stall_ready", 32'(rdy[0]), 0);
        end
        rd(2, 1'b1);
        #1 chk("stall_second", 32'(rdat0), 'h2222);
        rd(3, 1'b1);
        #1 chk("stall_third", 32'(rdat0), 'hAB34);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        #1 chk("drain_valid", 32'(rv[0]), 0);

        wr(7, 'h00FF, 3);
        wr(7, 'h5555, 3);
        #1;
        chk("wr_rsp_data", 32'(rdat1), 'h00FF);
        chk("wr_rsp_valid", 32'(rv), 2);
        rd(7, 1'b1);
        #1;
        chk("rd7_dut0", 32'(rdat0), 'h5555);
        chk("rd7_dut1", 32'(rdat1), 'h5555);

        wr(20, 'hDEAD, 3);
        rd(20, 1'b1);
        #1;
        chk("oor_data", 32'(rdat0), 0);
        chk("oor_valid", 32'(rv[0]), 1);
        rd(4, 1'b1);
        #1 chk("oor_no_alias", 32'(rdat0), 'h4444);
        rd(5, 1'b1);
        #1 chk("be_zero", 32'(rdat0), 0);

        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, DEP + 3), $urandom_range(0, 'hFFFF), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0);
        end

        cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, i, 'hBEEF, 3, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 2, 'hBEEF, 3, 1'b1);
        count_clear("restart_len");
        for (int a = 0; a < DEP; a++) rd(a, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
